// File: rtl/mips32_mem_arbiter.sv
// Arbiter sharing one single-ported synchronous memory between IF fetch and MEM data access.
// Optional fetch starvation guard enabled by defining MIPS32_ARB_STARVE_GUARD_EN.
module mips32_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              halted,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic arb_ok;
    logic if_elig;
    logic force_fetch;
    logic pick_d;
    logic pick_if;
    logic cur_fetch;
    logic cur_read;

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

    // Arbitration is only legal outside GRANT, giving one access every two cycles.
    always_comb begin
        arb_ok  = (state != GRANT);
        if_elig = if_req & ~halted;
        pick_d  = arb_ok & d_req & ~force_fetch;
        pick_if = arb_ok & if_elig & ~pick_d;
    end

`ifdef MIPS32_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    // Counts data grants that overtook an eligible waiting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!if_req || pick_if) begin
            starve_cnt <= '0;
        end else if (pick_d && !halted) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign force_fetch = if_elig && (starve_cnt == CNT_W'(STARVE_MAX));
`else
    assign force_fetch = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_d || pick_if) state_next = GRANT;
            GRANT:   state_next = RESP;
            RESP:    state_next = (pick_d || pick_if) ? GRANT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command outputs are only loaded on entry to GRANT, so they self-clear in every other cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cur_fetch <= 1'b0;
            cur_read  <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_gnt    <= pick_if;
            d_gnt     <= pick_d;
            mem_en    <= pick_d | pick_if;
            mem_we    <= pick_d & d_we;
            mem_addr  <= pick_d ? d_addr : (pick_if ? if_addr : '0);
            mem_wdata <= pick_d ? d_wdata : '0;
            if (pick_d || pick_if) begin
                cur_fetch <= pick_if;
                cur_read  <= pick_if | ~d_we;
            end
            if_rvalid <= (state == RESP) && cur_read && cur_fetch;
            d_rvalid  <= (state == RESP) && cur_read && !cur_fetch;
            if ((state == RESP) && cur_read && cur_fetch) begin
                if_rdata <= mem_rdata;
            end
            if ((state == RESP) && cur_read && !cur_fetch) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model (grant order, memory image, response timing).
module tb_mips32_mem_arbiter;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              halted;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    mips32_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .halted   (halted),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array the arbiter drives; ref_mem is the model's view of the same contents.
    logic [DATA_W-1:0] tb_mem  [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dreq_t;

    typedef struct {
        bit                v;
        bit                fetch;
        bit                read;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] data;
    } grec_t;

    dreq_t             d_q[$];
    logic [ADDR_W-1:0] f_q[$];
    bit                seq[$];
    grec_t             g_prev;
    grec_t             g_prev2;
    int                starve;
    int                n_cmp;
    int                n_fail;
    int                obs_fg;
    int                obs_dg;
    int                obs_frv;
    int                obs_drv;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        if_req  = (f_q.size() > 0);
        if_addr = (f_q.size() > 0) ? f_q[0] : '0;
        d_req   = (d_q.size() > 0);
        d_we    = (d_q.size() > 0) ? d_q[0].we : 1'b0;
        d_addr  = (d_q.size() > 0) ? d_q[0].addr : '0;
        d_wdata = (d_q.size() > 0) ? d_q[0].wdata : '0;
    endtask

    task automatic clearModel();
        g_prev  = '{default: '0};
        g_prev2 = '{default: '0};
        starve  = 0;
    endtask

    // One clock: sample the requests seen at the edge, predict that cycle's grant and response, compare.
    task automatic stepCycle();
        bit                s_if;
        bit                s_d;
        bit                s_halt;
        bit                fe;
        bit                frc;
        dreq_t             sd;
        logic [ADDR_W-1:0] sf;
        grec_t             g_now;
        @(posedge clk);
        s_if     = if_req;
        s_d      = d_req;
        s_halt   = halted;
        sd.we    = d_we;
        sd.addr  = d_addr;
        sd.wdata = d_wdata;
        sf       = if_addr;
        #1;
        g_now = '{default: '0};
        if (!g_prev.v) begin
            fe  = s_if && !s_halt;
            frc = 1'b0;
`ifdef MIPS32_ARB_STARVE_GUARD_EN
            frc = fe && (starve == STARVE_MAX);
`endif
            if (s_d && !frc) begin
                g_now.v     = 1'b1;
                g_now.we    = sd.we;
                g_now.read  = !sd.we;
                g_now.addr  = sd.addr;
                g_now.wdata = sd.wdata;
                g_now.data  = ref_mem[sd.addr];
                if (sd.we) ref_mem[sd.addr] = sd.wdata;
            end else if (fe) begin
                g_now.v     = 1'b1;
                g_now.fetch = 1'b1;
                g_now.read  = 1'b1;
                g_now.addr  = sf;
                g_now.data  = ref_mem[sf];
            end
        end
`ifdef MIPS32_ARB_STARVE_GUARD_EN
        if (!s_if) starve = 0;
        else if (g_now.v && g_now.fetch) starve = 0;
        else if (g_now.v && !s_halt) starve++;
`endif
        checkOutput("d_gnt", d_gnt, g_now.v && !g_now.fetch);
        checkOutput("if_gnt", if_gnt, g_now.v && g_now.fetch);
        checkOutput("mem_en", mem_en, g_now.v);
        checkOutput("mem_we", mem_we, g_now.v && g_now.we);
        checkOutput("mem_addr", mem_addr, g_now.v ? g_now.addr : '0);
        if (!g_now.v || g_now.we) checkOutput("mem_wdata", mem_wdata, g_now.v ? g_now.wdata : '0);
        checkOutput("d_rvalid", d_rvalid, g_prev2.v && g_prev2.read && !g_prev2.fetch);
        checkOutput("if_rvalid", if_rvalid, g_prev2.v && g_prev2.fetch);
        if (g_prev2.v && g_prev2.read && !g_prev2.fetch) checkOutput("d_rdata", d_rdata, g_prev2.data);
        if (g_prev2.v && g_prev2.fetch) checkOutput("if_rdata", if_rdata, g_prev2.data);
        if (d_gnt || if_gnt) seq.push_back(if_gnt);
        if (if_gnt)    obs_fg++;
        if (d_gnt)     obs_dg++;
        if (if_rvalid) obs_frv++;
        if (d_rvalid)  obs_drv++;
        if (g_now.v && g_now.fetch)  void'(f_q.pop_front());
        if (g_now.v && !g_now.fetch) void'(d_q.pop_front());
        g_prev2 = g_prev;
        g_prev  = g_now;
        applyStimulus();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    function automatic logic [31:0] packSeq(input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n && i < seq.size(); i++) r[i] = seq[i];
        return r;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".if_gnt"}, if_gnt, 1'b0);
        checkOutput({tag, ".d_gnt"}, d_gnt, 1'b0);
        checkOutput({tag, ".if_rvalid"}, if_rvalid, 1'b0);
        checkOutput({tag, ".d_rvalid"}, d_rvalid, 1'b0);
        checkOutput({tag, ".if_rdata"}, if_rdata, '0);
        checkOutput({tag, ".d_rdata"}, d_rdata, '0);
        checkOutput({tag, ".mem_en"}, mem_en, 1'b0);
        checkOutput({tag, ".mem_we"}, mem_we, 1'b0);
        checkOutput({tag, ".mem_addr"}, mem_addr, '0);
        checkOutput({tag, ".mem_wdata"}, mem_wdata, '0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dreq_t dr;
        int    base_fg;
        int    base_dg;
        int    base_frv;
        n_cmp  = 0;
        n_fail = 0;
        obs_fg = 0; obs_dg = 0; obs_frv = 0; obs_drv = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[120]  = 32'd85;
        ref_mem[120] = 32'd85;
        mem_rdata = '0;
        halted    = 1'b0;
        clearModel();
        applyStimulus();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2 checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single load from address 120");
        dr = '{we: 1'b0, addr: 10'd120, wdata: '0};
        d_q.push_back(dr);
        applyStimulus();
        runCycles(5);
        checkOutput("load120.d_rdata", d_rdata, 32'd85);
        checkOutput("load120.if_gnt_count", obs_fg, 0);

        $display("[TB] store 130 to 121 then fetch it back");
        dr = '{we: 1'b1, addr: 10'd121, wdata: 32'd130};
        d_q.push_back(dr);
        applyStimulus();
        runCycles(4);
        f_q.push_back(10'd121);
        applyStimulus();
        runCycles(5);
        checkOutput("fetch121.if_rdata", if_rdata, 32'd130);

        $display("[TB] simultaneous fetch and load");
        seq.delete();
        f_q.push_back(10'd5);
        dr = '{we: 1'b0, addr: 10'd6, wdata: '0};
        d_q.push_back(dr);
        applyStimulus();
        runCycles(7);
        checkOutput("simul.grant_count", seq.size(), 2);
        checkOutput("simul.order", packSeq(2), 32'b10);

        $display("[TB] starvation with data held continuously");
        seq.delete();
        for (int i = 0; i < 10; i++) begin
            dr = '{we: 1'b0, addr: ADDR_W'(200 + i), wdata: '0};
            d_q.push_back(dr);
        end
        f_q.push_back(10'd9);
        applyStimulus();
        runCycles(20);
`ifdef MIPS32_ARB_STARVE_GUARD_EN
        checkOutput("starve.order", packSeq(6), 32'b010000);
`else
        checkOutput("starve.order", packSeq(6), 32'b000000);
`endif
        runCycles(6);
        checkOutput("starve.drained", d_q.size() + f_q.size(), 0);

        $display("[TB] halted blocks fetch but not data");
        base_fg = obs_fg;
        base_dg = obs_dg;
        halted  = 1'b1;
        f_q.push_back(10'd7);
        dr = '{we: 1'b0, addr: 10'd8, wdata: '0};
        d_q.push_back(dr);
        applyStimulus();
        runCycles(10);
        checkOutput("halt.if_gnt_count", obs_fg - base_fg, 0);
        checkOutput("halt.d_gnt_count", obs_dg - base_dg, 1);
        halted = 1'b0;
        runCycles(4);
        checkOutput("unhalt.if_gnt_count", obs_fg - base_fg, 1);

        $display("[TB] halted rising during a fetch grant");
        base_frv = obs_frv;
        f_q.push_back(10'd11);
        applyStimulus();
        stepCycle();
        halted = 1'b1;
        runCycles(3);
        checkOutput("halt_mid.if_rvalid_count", obs_frv - base_frv, 1);
        halted = 1'b0;

        $display("[TB] reset during RESP of a load");
        base_dg = obs_drv;
        dr = '{we: 1'b0, addr: 10'd120, wdata: '0};
        d_q.push_back(dr);
        applyStimulus();
        stepCycle();
        stepCycle();
        rst_n = 1'b0;
        #1 checkAllZero("midreset");
        d_q.delete();
        f_q.delete();
        clearModel();
        applyStimulus();
        @(negedge clk);
        rst_n = 1'b1;
        runCycles(3);
        checkOutput("midreset.d_rvalid_count", obs_drv - base_dg, 0);
        dr = '{we: 1'b0, addr: 10'd121, wdata: '0};
        d_q.push_back(dr);
        applyStimulus();
        runCycles(4);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 500; c++) begin
            if (d_q.size() < 2 && $urandom_range(0, 2) == 0) begin
                dr.we    = $urandom_range(0, 1);
                dr.addr  = ADDR_W'($urandom_range(0, 15));
                dr.wdata = $urandom;
                d_q.push_back(dr);
            end
            if (f_q.size() < 2 && $urandom_range(0, 2) == 0) begin
                f_q.push_back(ADDR_W'($urandom_range(0, 15)));
            end
            halted = ($urandom_range(0, 9) == 0);
            applyStimulus();
            stepCycle();
        end
        halted = 1'b0;
        for (int c = 0; c < 40 && (d_q.size() + f_q.size()) > 0; c++) stepCycle();
        runCycles(3);
        checkOutput("random.drained", d_q.size() + f_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

- Shares one single-ported synchronous memory between two requesters of the pipelined MIPS32 core: instruction fetch (IF stage, read-only) and data access (MEM stage, LW/SW).
- Sits between the pipeline stages and the unified instruction/data memory array.
- Serialises accesses with a three-state FSM; data has priority, with an optional fetch starvation guard.
- Stops granting fetches once the core is halted.

## Interface

Parameters:

- ADDR_W, 10, word address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants tolerated while a fetch waits (used only with the starvation guard)

Ports:

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  one-cycle pulse: fetch command issued this cycle
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched instruction word (registered)
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data command issued this cycle
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only)
- d_rdata  out  DATA_W  load data (registered)
- halted  in  1  core HALTED flag; blocks new fetch grants
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read command

## Operation

States:

- IDLE: no command.
- GRANT: mem_en=1 with the registered command; the matching gnt is high.
- RESP: mem_rdata valid for a read.

Transitions:

- IDLE → GRANT when an eligible request is present; otherwise stay in IDLE.
- GRANT → RESP unconditionally.
- RESP → GRANT if an eligible request is present; otherwise RESP → IDLE.

Arbitration and commands:

- Arbitration happens in IDLE and RESP only. Requests are sampled at the edge that ends the cycle.
- Eligibility: d_req is always eligible. if_req is eligible only when halted=0.
- Winner: data beats fetch, unless the starvation guard forces fetch (see Configuration).
- The winner's command (we, addr, wdata) is registered onto the mem_* outputs on entry to GRANT. A fetch always has mem_we=0.
- Requesters must drop or change req/address at the edge ending the gnt cycle. A req still high in RESP is treated as a new request.

Responses:

- On a read, mem_rdata is captured at the edge ending RESP into if_rdata or d_rdata. The matching rvalid is high for the following cycle.
- A store produces no rvalid; it is complete at the edge ending GRANT.
- halted rising mid-transaction does not cancel an already-granted fetch; its rvalid is still delivered.
- Reset: all outputs 0, state IDLE, starvation counter 0. An in-flight transaction is dropped and produces no rvalid.

## Timing

- Request seen at edge E0 → gnt and mem_en in cycle E0+1 → mem_rdata in E0+2 → rvalid and rdata in E0+3.
- Throughput: one access per 2 cycles under continuous requests.
- The rvalid of access k coincides with the GRANT cycle of access k+1.
- mem_en, mem_we, mem_addr and mem_wdata are deasserted (0) in every non-GRANT cycle.
- if_gnt and d_gnt are never high in the same cycle. The same applies to if_rvalid and d_rvalid.

## Configuration

- MIPS32_ARB_STARVE_GUARD_EN defined:
  - A counter increments on each data grant made while if_req=1 and halted=0.
  - It clears on any fetch grant, or whenever if_req=0.
  - When the counter equals STARVE_MAX and fetch is eligible, the next grant goes to fetch even if d_req=1.
- Undefined: strict data priority; fetch can starve indefinitely and no counter logic exists.

## Test plan

- Single load: mem[120]=85; d_req, d_we=0, d_addr=120 from IDLE → d_gnt 1 cycle later, d_rvalid with d_rdata=85 three cycles after the request; if_* idle.
- Store then fetch: d_we=1, d_addr=121, d_wdata=130 → mem_we=1, mem_addr=121 for one cycle. A later if_req at if_addr=121 → if_rdata=130, if_rvalid pulse.
- Simultaneous requests: if_req and d_req both raised in IDLE → d_gnt first; if_gnt in the next GRANT two cycles later; no overlapping gnt or rvalid.
- Starvation (macro on, STARVE_MAX=4): d_req held high with incrementing addresses, if_req high → exactly 4 d_gnt, then 1 if_gnt, then data resumes. Macro off → 0 if_gnt.
- Halt: halted=1 with if_req=1 → no if_gnt for 10 cycles; d_req still served. halted asserted during a fetch's GRANT → that fetch's if_rvalid still delivered.
- Reset mid-operation: rst_n low during RESP of a load → all outputs 0 immediately, no d_rvalid after release. First grant comes 1 cycle after a request sampled post-reset.
